// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and write-back controller.
// Drives one register-file write port; dual writes take two beats.
module mem_wb_stage #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [REG_ADDR_W-1:0] Rdst1_in,
  input  logic [DATA_W-1:0]     Rdst1_val_in,
  input  logic [REG_ADDR_W-1:0] Rdst2_in,
  input  logic [DATA_W-1:0]     Rdst2_val_in,
  input  logic                  reglow_write_in,
  input  logic                  reghigh_write_in,
  input  logic                  memToReg_in,
  input  logic [DATA_W-1:0]     Data_in,
  input  logic                  stall_in,
  input  logic                  flush_in,
  output logic                  rf_we_out,
  output logic [REG_ADDR_W-1:0] rf_addr_out,
  output logic [DATA_W-1:0]     rf_data_out,
  output logic                  stall_out,
  output logic [CNT_W-1:0]      retired_out
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rdst1;
    logic [REG_ADDR_W-1:0] rdst2;
    logic [DATA_W-1:0]     wb1;
    logic [DATA_W-1:0]     rdst2_val;
    logic                  lo;
    logic                  hi;
  } wb_reg_t;

  typedef enum logic {
    FIRST,
    SECOND
  } state_t;

  wb_reg_t          r, r_nxt;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             beat2, beat_lo, beat_hi;

  assign stall_out = (state == FIRST) & r.valid & r.lo & r.hi;

  assign beat2   = (state == SECOND) & r.valid;
  assign beat_lo = (state == FIRST) & r.valid & r.lo;
  assign beat_hi = (state == FIRST) & r.valid & ~r.lo & r.hi;

  always_comb begin
    rf_we_out   = 1'b0;
    rf_addr_out = '0;
    rf_data_out = '0;
    unique case (1'b1)
      beat2: begin
        rf_we_out   = 1'b1;
        rf_addr_out = r.rdst2;
        rf_data_out = r.rdst2_val;
      end
      beat_lo: begin
        rf_we_out   = 1'b1;
        rf_addr_out = r.rdst1;
        rf_data_out = r.wb1;
      end
      beat_hi: begin
        rf_we_out   = 1'b1;
        rf_addr_out = r.rdst2;
        rf_data_out = r.rdst2_val;
      end
      default: ;
    endcase
  end

  // Stall wins: the held MEM slot is re-presented, so flush/stall_in wait.
  always_comb begin
    r_nxt = r;
    if (!stall_out) begin
      if (flush_in | stall_in) begin
        r_nxt = '0;
      end else begin
        r_nxt.valid     = valid_in;
        r_nxt.rdst1     = Rdst1_in;
        r_nxt.rdst2     = Rdst2_in;
        r_nxt.wb1       = memToReg_in ? Data_in : Rdst1_val_in;
        r_nxt.rdst2_val = Rdst2_val_in;
        r_nxt.lo        = valid_in & reglow_write_in;
        r_nxt.hi        = valid_in & reghigh_write_in;
      end
    end
  end

  always_comb begin
    state_nxt = FIRST;
    if (stall_out) state_nxt = SECOND;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r     <= '0;
      state <= FIRST;
      cnt   <= '0;
    end else begin
      r     <= r_nxt;
      state <= state_nxt;
      if (!stall_out && r.valid) cnt <= cnt + CNT_W'(1);
    end
  end

  assign retired_out = cnt;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
// A second instance with a 4-bit counter checks wrap-around.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [2:0]  Rdst1_in;
  logic [15:0] Rdst1_val_in;
  logic [2:0]  Rdst2_in;
  logic [15:0] Rdst2_val_in;
  logic        reglow_write_in;
  logic        reghigh_write_in;
  logic        memToReg_in;
  logic [15:0] Data_in;
  logic        stall_in;
  logic        flush_in;
  logic        rf_we_out;
  logic [2:0]  rf_addr_out;
  logic [15:0] rf_data_out;
  logic        stall_out;
  logic [15:0] retired_out;
  logic        we4;
  logic [2:0]  addr4;
  logic [15:0] data4;
  logic        stall4;
  logic [3:0]  retired4;

  int          errors = 0;
  int          checks = 0;
  logic [15:0] exp_ret;

  always #5 clk = ~clk;

  mem_wb_stage u_dut (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .Rdst1_in(Rdst1_in), .Rdst1_val_in(Rdst1_val_in),
    .Rdst2_in(Rdst2_in), .Rdst2_val_in(Rdst2_val_in),
    .reglow_write_in(reglow_write_in),
    .reghigh_write_in(reghigh_write_in),
    .memToReg_in(memToReg_in), .Data_in(Data_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .rf_we_out(rf_we_out), .rf_addr_out(rf_addr_out),
    .rf_data_out(rf_data_out), .stall_out(stall_out),
    .retired_out(retired_out)
  );

  mem_wb_stage #(.CNT_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .valid_in(valid_in),
    .Rdst1_in(Rdst1_in), .Rdst1_val_in(Rdst1_val_in),
    .Rdst2_in(Rdst2_in), .Rdst2_val_in(Rdst2_val_in),
    .reglow_write_in(reglow_write_in),
    .reghigh_write_in(reghigh_write_in),
    .memToReg_in(memToReg_in), .Data_in(Data_in),
    .stall_in(stall_in), .flush_in(flush_in),
    .rf_we_out(we4), .rf_addr_out(addr4),
    .rf_data_out(data4), .stall_out(stall4),
    .retired_out(retired4)
  );

  task automatic drive(input logic v, input logic [2:0] a1,
                       input logic [15:0] d1, input logic [2:0] a2,
                       input logic [15:0] d2, input logic lo,
                       input logic hi, input logic m2r,
                       input logic [15:0] dat, input logic st,
                       input logic fl);
    valid_in         = v;
    Rdst1_in         = a1;
    Rdst1_val_in     = d1;
    Rdst2_in         = a2;
    Rdst2_val_in     = d2;
    reglow_write_in  = lo;
    reghigh_write_in = hi;
    memToReg_in      = m2r;
    Data_in          = dat;
    stall_in         = st;
    flush_in         = fl;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [63:0] rnd;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      rnd = {$urandom, $urandom};
      drive(rnd[0], rnd[3:1], rnd[19:4], rnd[22:20], rnd[38:23],
            rnd[39], rnd[40], rnd[41], rnd[57:42], rnd[58], rnd[59]);
      @(negedge clk);
      checks++;
      if (rf_we_out !== 1'b0 || stall_out !== 1'b0 ||
          retired_out !== 16'd0 || rf_addr_out !== 3'd0 ||
          rf_data_out !== 16'd0) begin
        errors++;
        $display("FAIL reset_hold: we=%b stall=%b ret=%0d addr=%0d data=%h, want all 0",
                 rf_we_out, stall_out, retired_out, rf_addr_out, rf_data_out);
      end
    end
    tick();
    reset = 1'b1;
    idle();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || stall_out !== 1'b0 || retired_out !== 16'd0) begin
      errors++;
      $display("FAIL reset_release: we=%b stall=%b ret=%0d, want 0 0 0",
               rf_we_out, stall_out, retired_out);
    end
    exp_ret = 16'd0;
  endtask

  task automatic test_single_load();
    drive(1, 3, 16'h0000, 0, 0, 1, 0, 1, 16'hBEEF, 0, 0);
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd3 ||
        rf_data_out !== 16'hBEEF || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL load_wb: we=%b addr=%0d data=%h stall=%b, want 1 3 beef 0",
               rf_we_out, rf_addr_out, rf_data_out, stall_out);
    end
    tick();
    @(negedge clk);
    checks++;
    if (retired_out !== 16'd1 || rf_we_out !== 1'b0 ||
        rf_addr_out !== 3'd0 || rf_data_out !== 16'd0) begin
      errors++;
      $display("FAIL load_retire: ret=%0d we=%b addr=%0d data=%h, want 1 0 0 0",
               retired_out, rf_we_out, rf_addr_out, rf_data_out);
    end
    exp_ret = 16'd1;
  endtask

  task automatic test_variants();
    drive(1, 1, 16'h1234, 0, 0, 1, 0, 0, 16'hFFFF, 0, 0);
    tick();
    drive(1, 0, 0, 4, 16'h5A5A, 0, 1, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd1 || rf_data_out !== 16'h1234) begin
      errors++;
      $display("FAIL alu_wb: we=%b addr=%0d data=%h, want 1 1 1234",
               rf_we_out, rf_addr_out, rf_data_out);
    end
    tick();
    drive(1, 5, 16'h1111, 6, 16'h2222, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd4 ||
        rf_data_out !== 16'h5A5A || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL hi_only: we=%b addr=%0d data=%h stall=%b, want 1 4 5a5a 0",
               rf_we_out, rf_addr_out, rf_data_out, stall_out);
    end
    tick();
    drive(0, 2, 16'h9999, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || rf_addr_out !== 3'd0 || rf_data_out !== 16'd0) begin
      errors++;
      $display("FAIL no_enable: we=%b addr=%0d data=%h, want 0 0 0",
               rf_we_out, rf_addr_out, rf_data_out);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || retired_out !== exp_ret + 16'd3) begin
      errors++;
      $display("FAIL invalid_in: we=%b ret=%0d, want 0 %0d",
               rf_we_out, retired_out, exp_ret + 16'd3);
    end
    exp_ret = exp_ret + 16'd3;
  endtask

  task automatic test_dual_write();
    drive(1, 2, 16'h1111, 5, 16'h2222, 1, 1, 0, 16'hDEAD, 0, 0);
    tick();
    drive(1, 7, 16'h7777, 0, 0, 1, 0, 0, 0, 0, 0);
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd2 || rf_data_out !== 16'h1111 ||
        stall_out !== 1'b1 || retired_out !== exp_ret) begin
      errors++;
      $display("FAIL dual_beat1: we=%b addr=%0d data=%h stall=%b ret=%0d, want 1 2 1111 1 %0d",
               rf_we_out, rf_addr_out, rf_data_out, stall_out, retired_out, exp_ret);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd5 || rf_data_out !== 16'h2222 ||
        stall_out !== 1'b0 || retired_out !== exp_ret) begin
      errors++;
      $display("FAIL dual_beat2: we=%b addr=%0d data=%h stall=%b ret=%0d, want 1 5 2222 0 %0d",
               rf_we_out, rf_addr_out, rf_data_out, stall_out, retired_out, exp_ret);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd7 || rf_data_out !== 16'h7777 ||
        stall_out !== 1'b0 || retired_out !== exp_ret + 16'd1) begin
      errors++;
      $display("FAIL dual_next: we=%b addr=%0d data=%h stall=%b ret=%0d, want 1 7 7777 0 %0d",
               rf_we_out, rf_addr_out, rf_data_out, stall_out, retired_out,
               exp_ret + 16'd1);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || retired_out !== exp_ret + 16'd2) begin
      errors++;
      $display("FAIL dual_retire: we=%b ret=%0d, want 0 %0d",
               rf_we_out, retired_out, exp_ret + 16'd2);
    end
    exp_ret = exp_ret + 16'd2;
  endtask

  task automatic test_push_pop_squash();
    drive(1, 4, 16'h4444, 0, 0, 1, 0, 0, 0, 0, 0);
    tick();
    drive(1, 4, 16'h4444, 0, 0, 1, 0, 0, 0, 1, 0);
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd4 || rf_data_out !== 16'h4444) begin
      errors++;
      $display("FAIL pp_first: we=%b addr=%0d data=%h, want 1 4 4444",
               rf_we_out, rf_addr_out, rf_data_out);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || retired_out !== exp_ret + 16'd1) begin
      errors++;
      $display("FAIL pp_bubble: we=%b ret=%0d, want 0 %0d",
               rf_we_out, retired_out, exp_ret + 16'd1);
    end
    tick();
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || retired_out !== exp_ret + 16'd1) begin
      errors++;
      $display("FAIL pp_noretire: we=%b ret=%0d, want 0 %0d",
               rf_we_out, retired_out, exp_ret + 16'd1);
    end
    exp_ret = exp_ret + 16'd1;
  endtask

  task automatic test_flush_dual(input logic keep_flush);
    drive(1, 1, 16'hAAAA, 6, 16'hBBBB, 1, 1, 0, 0, 0, 0);
    tick();
    drive(1, 3, 16'h3333, 0, 0, 1, 0, 0, 0, 0, 1);
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd1 ||
        rf_data_out !== 16'hAAAA || stall_out !== 1'b1) begin
      errors++;
      $display("FAIL flush_beat1: we=%b addr=%0d data=%h stall=%b, want 1 1 aaaa 1",
               rf_we_out, rf_addr_out, rf_data_out, stall_out);
    end
    tick();
    flush_in = keep_flush;
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd6 ||
        rf_data_out !== 16'hBBBB || stall_out !== 1'b0) begin
      errors++;
      $display("FAIL flush_beat2: we=%b addr=%0d data=%h stall=%b, want 1 6 bbbb 0",
               rf_we_out, rf_addr_out, rf_data_out, stall_out);
    end
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (keep_flush) begin
      if (rf_we_out !== 1'b0 || retired_out !== exp_ret + 16'd1) begin
        errors++;
        $display("FAIL flush_bubble: we=%b ret=%0d, want 0 %0d",
                 rf_we_out, retired_out, exp_ret + 16'd1);
      end
      exp_ret = exp_ret + 16'd1;
    end else begin
      if (rf_we_out !== 1'b1 || rf_addr_out !== 3'd3 ||
          rf_data_out !== 16'h3333 || retired_out !== exp_ret + 16'd1) begin
        errors++;
        $display("FAIL flush_capture: we=%b addr=%0d data=%h ret=%0d, want 1 3 3333 %0d",
                 rf_we_out, rf_addr_out, rf_data_out, retired_out, exp_ret + 16'd1);
      end
      exp_ret = exp_ret + 16'd2;
      tick();
    end
  endtask

  task automatic test_reset_mid_dual();
    drive(1, 2, 16'hCAFE, 3, 16'hF00D, 1, 1, 0, 0, 0, 0);
    tick();
    idle();
    @(negedge clk);
    checks++;
    if (stall_out !== 1'b1 || rf_addr_out !== 3'd2) begin
      errors++;
      $display("FAIL rst_dual_pre: stall=%b addr=%0d, want 1 2",
               stall_out, rf_addr_out);
    end
    #1 reset = 1'b0;
    #1;
    checks++;
    if (rf_we_out !== 1'b0 || stall_out !== 1'b0 || retired_out !== 16'd0) begin
      errors++;
      $display("FAIL rst_async: we=%b stall=%b ret=%0d, want 0 0 0",
               rf_we_out, stall_out, retired_out);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rf_we_out !== 1'b0 || stall_out !== 1'b0 || retired_out !== 16'd0) begin
      errors++;
      $display("FAIL rst_no_beat2: we=%b stall=%b ret=%0d, want 0 0 0",
               rf_we_out, stall_out, retired_out);
    end
    exp_ret = 16'd0;
  endtask

  task automatic test_back_to_back_wrap();
    logic [15:0] d;
    for (int i = 0; i < 17; i++) begin
      d = 16'(i * 3 + 1);
      drive(1, 3'(i), d, 0, 0, 1, 0, 0, 0, 0, 0);
      tick();
      @(negedge clk);
      checks++;
      if (rf_we_out !== 1'b1 || rf_addr_out !== 3'(i) || rf_data_out !== d) begin
        errors++;
        $display("FAIL b2b_%0d: we=%b addr=%0d data=%h, want 1 %0d %h",
                 i, rf_we_out, rf_addr_out, rf_data_out, i % 8, d);
      end
    end
    idle();
    tick();
    @(negedge clk);
    checks++;
    if (retired4 !== 4'd1 || retired_out !== 16'd17) begin
      errors++;
      $display("FAIL wrap: ret4=%0d ret16=%0d, want 1 17", retired4, retired_out);
    end
  endtask

  initial begin
    reset = 1'b0;
    idle();
    test_reset();
    test_single_load();
    test_variants();
    test_dual_write();
    test_push_pop_squash();
    test_flush_dual(1'b0);
    test_flush_dual(1'b1);
    test_reset_mid_dual();
    test_back_to_back_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wb_stage.md
# mem_wb_stage

Pipeline register plus write-back controller between the MEM stage and the register file. It latches MEM results and selects the write-back value (memory/port data or ALU result). It drives a single register-file write port and serialises two-register writes (low and high destinations) into two beats, stalling upstream for the extra beat. It also squashes MEM's duplicate push/pop beat and keeps a retired-instruction counter.

## Interface
- DATA_W, 16, register/data width
- REG_ADDR_W, 3, register index width
- CNT_W, 16, retired-instruction counter width

Ports:
- clk  in  1  pipeline clock, rising edge
- reset  in  1  asynchronous, active-low; clears all state
- valid_in  in  1  MEM slot holds a real instruction
- Rdst1_in  in  REG_ADDR_W  low destination register
- Rdst1_val_in  in  DATA_W  ALU result for Rdst1
- Rdst2_in  in  REG_ADDR_W  high destination register
- Rdst2_val_in  in  DATA_W  value for Rdst2
- reglow_write_in  in  1  write Rdst1
- reghigh_write_in  in  1  write Rdst2
- memToReg_in  in  1  1: Rdst1 gets Data_in; 0: gets Rdst1_val_in
- Data_in  in  DATA_W  memory/port read data from MEM
- stall_in  in  1  MEM second push/pop beat (MEM stall output)
- flush_in  in  1  squash the instruction entering this stage
- rf_we_out  out  1  register-file write enable
- rf_addr_out  out  REG_ADDR_W  register-file write index
- rf_data_out  out  DATA_W  register-file write data; also the write-back forwarding value
- stall_out  out  1  freeze EX_MEM/MEM this cycle
- retired_out  out  CNT_W  count of valid instructions completed

## Operation
- Internal stage register R holds the following fields: valid, Rdst1, Rdst2, wb1 value, Rdst2_val, lo, hi.
- At capture, wb1 = memToReg_in ? Data_in : Rdst1_val_in.
- Two states: FIRST (reset state) and SECOND.
- FIRST with R.lo & R.hi: write Rdst1 with wb1, assert stall_out, hold R, and go to SECOND.
- SECOND: write Rdst2 with Rdst2_val, deassert stall_out, capture the next R, and return to FIRST.
- FIRST with R.lo only: single beat, writing Rdst1/wb1.
- FIRST with R.hi only: single beat, writing Rdst2/Rdst2_val.
- FIRST with neither enable: rf_we_out=0.
- rf_we_out requires R.valid.
- Capture priority on each rising edge:
  - (1) stall_out=1: hold R, inputs ignored.
  - (2) flush_in=1 or stall_in=1: load a bubble (valid=0, lo=0, hi=0).
  - (3) otherwise: load the inputs. If valid_in=0, lo and hi are forced to 0.
- stall_in bubbling ensures the duplicate MEM beat of PUSH/POP PC never writes the register file twice.
- Retire counter: increments when R.valid=1 and R is being replaced (not held). A dual write is counted once, on the SECOND-beat edge. The counter wraps modulo 2^CNT_W.
- rf_addr_out and rf_data_out are 0 whenever rf_we_out=0.

## Timing
- Reset (asynchronous, reset=0): R cleared, state FIRST, counter 0. All outputs 0 during and immediately after reset.
- Reset mid-dual-write: SECOND is abandoned and no second write occurs.
- Latency: a MEM result captured at edge N appears on the rf_* outputs during cycle N→N+1. The register file commits it at edge N+1.
- Dual write: beat 1 is cycle N→N+1 (stall_out=1), beat 2 is cycle N+1→N+2. The next instruction is captured at edge N+2.
- stall_out is combinational from R and state only, never from the current inputs. It is high for exactly one cycle per dual write.
- stall_in and flush_in together: a single bubble.
- stall_in or flush_in asserted while stall_out=1: ignored. The upstream source is frozen, so the MEM slot is re-presented.
- rf_data_out is stable for the full cycle so that it can feed MEM forwarding.

## Test plan
- Reset: hold reset=0 for 2 cycles with random inputs -> rf_we_out=0, stall_out=0, retired_out=0. Release -> state FIRST.
- Single load: valid_in=1, Rdst1=3, memToReg=1, Data_in=16'hBEEF, lo=1 -> one cycle later rf_we_out=1, rf_addr_out=3, rf_data_out=16'hBEEF. retired_out=1 after the following edge.
- Dual write: Rdst1=2, Rdst1_val=16'h1111, Rdst2=5, Rdst2_val=16'h2222, lo=hi=1, followed by a lo-only write to R7 -> beat1 writes R2=1111 with stall_out=1. Beat2 writes R5=2222 with stall_out=0. The R7 write occurs on the next cycle. retired_out increments by exactly 1 for the dual instruction.
- Push/pop squash: same lo=1 instruction presented for 2 cycles, with stall_in=1 on the second -> exactly one rf write. The second cycle produces a bubble and no retire.
- Flush during dual write: dual instruction in R with flush_in=1 asserted in beat1 -> both beats still write. The held input is then captured normally, or bubbled if flush_in is still high after SECOND.
- Counter wrap: CNT_W=4, 17 valid single-write instructions -> retired_out=1.
